// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the decode/control unit.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} ifetch_state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.funct7 = instr[31:25];
    f.funct3 = instr[14:12];
    f.opcode = instr[6:0];
    return f;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: imem req/gnt/rvalid, execute redirect, and the valid/ready link to decode.
interface ifetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr, opcode, funct3, funct7,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr, opcode, funct3, funct7,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter: reset load, redirect load (word aligned) and modulo +4 step.
module ifetch_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= {load_pc[XLEN-1:2], 2'b00};
    else if (inc)  pc <= pc + XLEN'(4);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem request, held result to decode, redirect with drain.
module ifetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);
  import riscv_pkg::*;

  ifetch_state_t   state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] id_pc_q;
  logic [31:0]     id_instr_q;
  logic            redir;
  logic            fetch_done;
  instr_fields_t   fields;

  assign redir      = bus.redirect_valid;
  assign fetch_done = (state == WAIT) && bus.imem_rvalid && !redir;

  ifetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redir),
    .load_pc (bus.redirect_pc),
    .inc     (fetch_done),
    .pc      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Redirect only picks the target state; the PC load happens in u_pc.
  // In DRAIN a response arriving with a redirect still retires the orphan,
  // otherwise the unit would wait for a response that never comes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = REQ;
      REQ:   if (bus.imem_gnt) state_nxt = redir ? DRAIN : WAIT;
      WAIT:  if (bus.imem_rvalid) state_nxt = redir ? REQ : HOLD;
             else if (redir)      state_nxt = DRAIN;
      HOLD:  if (redir || bus.id_ready) state_nxt = REQ;
      DRAIN: if (bus.imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = (state == REQ);
    bus.id_valid  = (state == HOLD);
    bus.imem_addr = pc;
    bus.id_pc     = id_pc_q;
    bus.id_instr  = id_instr_q;
    fields        = split_fields(id_instr_q);
    bus.opcode    = fields.opcode;
    bus.funct3    = fields.funct3;
    bus.funct7    = fields.funct7;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
    end else if (redir) begin
      id_instr_q <= NOP_INSTR;
    end else if (fetch_done) begin
      id_instr_q <= bus.imem_rdata;
      id_pc_q    <= pc;
    end
  end

endmodule
